// File: rtl/config_regbank_if.sv
// config_regbank_if - pad-side host bus of the configuration register bank.
//
// Groups the write port, commit/snapshot requests and the readback port that
// a slow external host drives through GPIO pads.
//   master modport : host side (drives requests, observes wr_ack_o / mux_o)
//   slave modport  : register bank side
// Signals:
//   reg_wr_i   write request (asynchronous to the bank clock)
//   reg_adr_i  register address, $clog2(NREGS) bits
//   reg_dat_i  write data, DW bits
//   commit_i   shadow->active commit request (asynchronous)
//   wr_ack_o   toggles once per accepted write
//   mux_adr_i  readback select, $clog2(NMUX) bits
//   snap_i     snapshot request (asynchronous)
//   mux_o      registered readback lane, MW bits
interface config_regbank_if #(
  parameter int NREGS = 4,
  parameter int DW    = 16,
  parameter int NMUX  = 8,
  parameter int MW    = 8
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(NMUX);

  logic          reg_wr_i;
  logic [AW-1:0] reg_adr_i;
  logic [DW-1:0] reg_dat_i;
  logic          commit_i;
  logic          wr_ack_o;
  logic [SW-1:0] mux_adr_i;
  logic          snap_i;
  logic [MW-1:0] mux_o;

  modport master (
    output reg_wr_i, reg_adr_i, reg_dat_i, commit_i, mux_adr_i, snap_i,
    input  wr_ack_o, mux_o
  );

  modport slave (
    input  reg_wr_i, reg_adr_i, reg_dat_i, commit_i, mux_adr_i, snap_i,
    output wr_ack_o, mux_o
  );
endinterface

// File: rtl/config_regbank.sv
// config_regbank - parametrised configuration register bank with pad-level
// write port, write-acknowledge toggle and coherent readback snapshot.
//
// Optional feature macro: CONFIG_REGBANK_SHADOW_EN
//   defined   : writes land in shadow registers, a commit_i rise copies all
//               shadows into the active registers in one cycle
//   undefined : writes update the active registers directly, commit_i ignored
//
// Ports:
//   clk_i    in   block clock
//   rst_n_i  in   asynchronous active-low reset
//   bus      slave modport of config_regbank_if (write/commit/snapshot
//            requests, address/data, wr_ack_o, readback select, mux_o)
//   regs_o   out  NREGS*DW flattened active registers, reg i at [i*DW +: DW]
//   mux_i    in   NMUX*MW flattened readback inputs, lane j at [j*MW +: MW]
module config_regbank #(
  parameter int                  NREGS   = 4,
  parameter int                  DW      = 16,
  parameter int                  NMUX    = 8,
  parameter int                  MW      = 8,
  parameter logic [NREGS*DW-1:0] RST_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  config_regbank_if.slave     bus,
  output logic [NREGS*DW-1:0] regs_o,
  input  logic [NMUX*MW-1:0]  mux_i
);

  localparam int SW    = $clog2(NMUX);
  localparam int NLANE = 1 << SW;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Pad synchronisers: bit 0 = write, bit 1 = commit, bit 2 = snapshot.
  // Two flops for metastability, a third as edge-detect history.
  // ---------------------------------------------------------------------------
  logic [2:0] pad_in;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] rise;

  assign pad_in = {bus.snap_i, bus.commit_i, bus.reg_wr_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= pad_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  logic wr_rise, commit_rise, snap_rise, snap_mode;
  assign wr_rise     = rise[0];
  assign commit_rise = rise[1];
  assign snap_rise   = rise[2];
  assign snap_mode   = s2_q[2];

  // Address/data pins are sampled unsynchronised; the host keeps them stable
  // across the whole synchroniser delay.
  logic wr_hit;
  assign wr_hit = wr_rise && (32'(bus.reg_adr_i) < NREGS);

  // ---------------------------------------------------------------------------
  // Write acknowledge toggle
  // ---------------------------------------------------------------------------
  logic wr_ack_q, wr_ack_d;
  assign wr_ack_d = wr_ack_q ^ wr_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wr_ack_q <= 1'b0;
    else          wr_ack_q <= wr_ack_d;
  end

  assign bus.wr_ack_o = wr_ack_q;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
`ifndef CONFIG_REGBANK_SHADOW_EN
  logic unused_commit;
  assign unused_commit = commit_rise;
`endif

  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic          sel;
      logic [DW-1:0] act_q, act_d;

      assign sel = wr_hit && (32'(bus.reg_adr_i) == gi);

`ifdef CONFIG_REGBANK_SHADOW_EN
      logic [DW-1:0] shd_q, shd_d;

      // Commit copies the pre-write shadow; a coincident write still lands in
      // the shadow and needs a later commit to become active.
      always_comb begin
        shd_d = shd_q;
        act_d = act_q;
        if (sel)         shd_d = bus.reg_dat_i;
        if (commit_rise) act_d = shd_q;
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) shd_q <= RST_VAL[gi*DW +: DW];
        else          shd_q <= shd_d;
      end
`else
      always_comb begin
        act_d = act_q;
        if (sel) act_d = bus.reg_dat_i;
      end
`endif

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) act_q <= RST_VAL[gi*DW +: DW];
        else          act_q <= act_d;
      end

      assign regs_o[gi*DW +: DW] = act_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Snapshot buffer and readback
  // ---------------------------------------------------------------------------
  logic [NMUX*MW-1:0] snap_q, snap_d, rd_src;

  assign snap_d = snap_rise ? mux_i : snap_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) snap_q <= '0;
    else          snap_q <= snap_d;
  end

  // Reading through snap_d makes the capture edge itself return captured
  // data, so snapshot mode never shows a stale buffer.
  assign rd_src = snap_mode ? snap_d : mux_i;

  // Lane table padded to a power of two; unused selects read zero.
  logic [MW-1:0] lanes [NLANE];

  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      if (gi < NMUX) begin : g_used
        assign lanes[gi] = rd_src[gi*MW +: MW];
      end else begin : g_pad
        assign lanes[gi] = '0;
      end
    end
  endgenerate

  logic [MW-1:0] mux_q, mux_d;
  assign mux_d = lanes[bus.mux_adr_i];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) mux_q <= '0;
    else          mux_q <= mux_d;
  end

  assign bus.mux_o = mux_q;

endmodule

// File: tb/tb_config_regbank.sv
module tb_config_regbank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_regbank_if #(.NREGS(4), .DW(16), .NMUX(8), .MW(8)) ifa ();
  config_regbank_if #(.NREGS(3), .DW(16), .NMUX(6), .MW(8)) ifb ();

  logic [63:0] regs_a;
  logic [63:0] mux_ia;
  logic [47:0] regs_b;
  logic [47:0] mux_ib;

  config_regbank #(
    .NREGS(4), .DW(16), .NMUX(8), .MW(8), .RST_VAL(64'h0)
  ) u_a (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (ifa),
    .regs_o (regs_a),
    .mux_i  (mux_ia)
  );

  config_regbank #(
    .NREGS(3), .DW(16), .NMUX(6), .MW(8), .RST_VAL(48'h0000_A5A5_0000)
  ) u_b (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (ifb),
    .regs_o (regs_b),
    .mux_i  (mux_ib)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          dut_b;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [63:0] exp_regs;
    logic        exp_ack;
  } wr_vec_t;

  typedef struct {
    bit         dut_b;
    logic [2:0] adr;
    logic [7:0] exp;
  } rd_vec_t;

  wr_vec_t wv [7];
  rd_vec_t rv [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input bit b, input logic [1:0] adr, input logic [15:0] dat);
    if (b) begin
      ifb.reg_adr_i = adr; ifb.reg_dat_i = dat; ifb.reg_wr_i = 1'b1;
    end else begin
      ifa.reg_adr_i = adr; ifa.reg_dat_i = dat; ifa.reg_wr_i = 1'b1;
    end
    tick(4);
    if (b) ifb.reg_wr_i = 1'b0;
    else   ifa.reg_wr_i = 1'b0;
    tick(4);
  endtask

`ifdef CONFIG_REGBANK_SHADOW_EN
  task automatic do_commit(input bit b);
    if (b) ifb.commit_i = 1'b1;
    else   ifa.commit_i = 1'b1;
    tick(4);
    if (b) ifb.commit_i = 1'b0;
    else   ifa.commit_i = 1'b0;
    tick(4);
  endtask
`endif

  initial begin
    logic [63:0] act_regs;
    logic        act_ack;
    logic [7:0]  act_mux;

    ifa.reg_wr_i = 0; ifa.reg_adr_i = '0; ifa.reg_dat_i = '0; ifa.commit_i = 0;
    ifa.mux_adr_i = '0; ifa.snap_i = 0;
    ifb.reg_wr_i = 0; ifb.reg_adr_i = '0; ifb.reg_dat_i = '0; ifb.commit_i = 0;
    ifb.mux_adr_i = '0; ifb.snap_i = 0;
    mux_ia = '0;
    mux_ib = '0;

    // write vectors: cumulative state, regs_o of DUT b zero-extended
    wv[0] = '{1'b0, 2'd1, 16'hBEEF, 64'h0000_0000_BEEF_0000, 1'b1};
    wv[1] = '{1'b1, 2'd3, 16'h7777, 64'h0000_0000_A5A5_0000, 1'b0};
    wv[2] = '{1'b0, 2'd3, 16'hC0DE, 64'hC0DE_0000_BEEF_0000, 1'b0};
    wv[3] = '{1'b1, 2'd2, 16'h1111, 64'h0000_1111_A5A5_0000, 1'b1};
    wv[4] = '{1'b0, 2'd1, 16'h0001, 64'hC0DE_0000_0001_0000, 1'b1};
    wv[5] = '{1'b1, 2'd0, 16'h2222, 64'h0000_1111_A5A5_2222, 1'b0};
    wv[6] = '{1'b0, 2'd0, 16'hFFFF, 64'hC0DE_0000_0001_FFFF, 1'b0};

    // live readback: a lanes 0..7 = 11..88, b lanes 0..5 = F1..F6
    rv[0] = '{1'b0, 3'd3, 8'h44};
    rv[1] = '{1'b0, 3'd7, 8'h88};
    rv[2] = '{1'b0, 3'd0, 8'h11};
    rv[3] = '{1'b1, 3'd5, 8'hF6};
    rv[4] = '{1'b1, 3'd7, 8'h00};
    rv[5] = '{1'b1, 3'd0, 8'hF1};
    rv[6] = '{1'b1, 3'd6, 8'h00};

    // ---- reset state ----
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst regs_a", regs_a, 64'h0);
    check("rst mux_a", {56'h0, ifa.mux_o}, 64'h0);
    check("rst ack_a", {63'h0, ifa.wr_ack_o}, 64'h0);
    check("rst regs_b", {16'h0, regs_b}, 64'h0000_0000_A5A5_0000);
    $display("reset: regs_a=%h regs_b=%h", regs_a, regs_b);

    // ---- write table ----
    for (int i = 0; i < 7; i++) begin
      do_write(wv[i].dut_b, wv[i].adr, wv[i].dat);
`ifdef CONFIG_REGBANK_SHADOW_EN
      do_commit(wv[i].dut_b);
`endif
      act_regs = wv[i].dut_b ? {16'h0, regs_b} : regs_a;
      act_ack  = wv[i].dut_b ? ifb.wr_ack_o : ifa.wr_ack_o;
      check($sformatf("wr%0d regs", i), act_regs, wv[i].exp_regs);
      check($sformatf("wr%0d ack", i), {63'h0, act_ack}, {63'h0, wv[i].exp_ack});
      $display("write %0d: dut=%s adr=%0d dat=%h regs=%h ack=%b",
               i, wv[i].dut_b ? "b" : "a", wv[i].adr, wv[i].dat, act_regs, act_ack);
    end

`ifndef CONFIG_REGBANK_SHADOW_EN
    // ---- direct write timing: update exactly 3 edges after the rise ----
    @(negedge clk);
    ifa.reg_adr_i = 2'd2; ifa.reg_dat_i = 16'h1234; ifa.reg_wr_i = 1'b1;
    @(posedge clk); #1;
    check("dir edge k", {48'h0, regs_a[47:32]}, 64'h0);
    @(posedge clk); #1;
    check("dir edge k+1", {48'h0, regs_a[47:32]}, 64'h0);
    check("dir ack k+1", {63'h0, ifa.wr_ack_o}, 64'h0);
    @(posedge clk); #1;
    check("dir edge k+2", {48'h0, regs_a[47:32]}, 64'h1234);
    check("dir ack k+2", {63'h0, ifa.wr_ack_o}, 64'h1);
    tick(2);
    ifa.reg_wr_i = 1'b0;
    tick(4);
    $display("direct timed write: regs=%h ack=%b", regs_a, ifa.wr_ack_o);
    do_write(1'b0, 2'd2, 16'h5678);
    check("dir second ack", {63'h0, ifa.wr_ack_o}, 64'h0);
    check("dir second regs", regs_a, 64'hC0DE_5678_0001_FFFF);
    $display("direct second write: regs=%h ack=%b", regs_a, ifa.wr_ack_o);
`else
    // ---- shadow: write invisible until commit, commit timing ----
    do_write(1'b0, 2'd0, 16'h00FF);
    check("shd write hidden", regs_a, 64'hC0DE_0000_0001_FFFF);
    check("shd ack", {63'h0, ifa.wr_ack_o}, 64'h1);
    @(negedge clk);
    ifa.commit_i = 1'b1;
    @(posedge clk); #1;
    check("shd commit k", {48'h0, regs_a[15:0]}, 64'hFFFF);
    @(posedge clk); #1;
    check("shd commit k+1", {48'h0, regs_a[15:0]}, 64'hFFFF);
    @(posedge clk); #1;
    check("shd commit k+2", {48'h0, regs_a[15:0]}, 64'h00FF);
    tick(2);
    ifa.commit_i = 1'b0;
    tick(4);
    $display("shadow commit: regs=%h", regs_a);
    // write and commit rising together: old shadow committed
    do_write(1'b0, 2'd0, 16'hAAAA);
    check("shd second hidden", {48'h0, regs_a[15:0]}, 64'h00FF);
    @(negedge clk);
    ifa.reg_adr_i = 2'd0; ifa.reg_dat_i = 16'h5555;
    ifa.reg_wr_i = 1'b1; ifa.commit_i = 1'b1;
    tick(4);
    ifa.reg_wr_i = 1'b0; ifa.commit_i = 1'b0;
    tick(4);
    check("shd simul old", {48'h0, regs_a[15:0]}, 64'hAAAA);
    check("shd simul ack", {63'h0, ifa.wr_ack_o}, 64'h1);
    do_commit(1'b0);
    check("shd simul recommit", {48'h0, regs_a[15:0]}, 64'h5555);
    $display("shadow simultaneous write+commit: regs=%h", regs_a);
`endif

    // ---- live readback table ----
    mux_ia = 64'h8877_6655_4433_2211;
    mux_ib = 48'hF6F5_F4F3_F2F1;
    tick(2);
    for (int i = 0; i < 7; i++) begin
      if (rv[i].dut_b) ifb.mux_adr_i = rv[i].adr;
      else             ifa.mux_adr_i = rv[i].adr;
      @(negedge clk);
      act_mux = rv[i].dut_b ? ifb.mux_o : ifa.mux_o;
      check($sformatf("rd%0d mux", i), {56'h0, act_mux}, {56'h0, rv[i].exp});
      $display("read %0d: dut=%s adr=%0d mux=%h", i, rv[i].dut_b ? "b" : "a", rv[i].adr, act_mux);
    end

    // ---- snapshot coherence ----
    mux_ia = 64'h0000_0000_0012_3400;
    ifa.mux_adr_i = 3'd1;
    @(negedge clk);
    check("snap live before", {56'h0, ifa.mux_o}, 64'h34);
    ifa.snap_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("snap first read", {56'h0, ifa.mux_o}, 64'h34);
    mux_ia = '1;
    @(negedge clk);
    check("snap hold lane1", {56'h0, ifa.mux_o}, 64'h34);
    ifa.mux_adr_i = 3'd2;
    @(negedge clk);
    check("snap hold lane2", {56'h0, ifa.mux_o}, 64'h12);
    ifa.mux_adr_i = 3'd1;
    ifa.snap_i = 1'b0;
    tick(4);
    check("snap released", {56'h0, ifa.mux_o}, 64'hFF);
    $display("snapshot sequence done: mux=%h", ifa.mux_o);

    // ---- reset mid-snapshot, and write held high across reset release ----
    mux_ia = {8{8'h5A}};
    ifa.snap_i = 1'b1;
    tick(5);
    check("pre-rst snap", {56'h0, ifa.mux_o}, 64'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("rst mux immediate", {56'h0, ifa.mux_o}, 64'h0);
    check("rst regs immediate", regs_a, 64'h0);
    check("rst ack immediate", {63'h0, ifa.wr_ack_o}, 64'h0);
    ifa.snap_i = 1'b0;
    ifa.reg_adr_i = 2'd0; ifa.reg_dat_i = 16'h4242; ifa.reg_wr_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-rst ack", {63'h0, ifa.wr_ack_o}, 64'h1);
`ifdef CONFIG_REGBANK_SHADOW_EN
    check("post-rst hidden", regs_a, 64'h0);
`else
    check("post-rst write", regs_a, 64'h4242);
`endif
    tick(2);
    ifa.reg_wr_i = 1'b0;
    tick(4);
`ifdef CONFIG_REGBANK_SHADOW_EN
    do_commit(1'b0);
    check("post-rst commit", regs_a, 64'h4242);
`endif
    $display("reset-release write: regs=%h ack=%b", regs_a, ifa.wr_ack_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
